// File: rtl/cpu_consts_pkg.sv
// Shared CPU encodings: access sizes, memory-access FSM states, writeback
// source selects, plus small helpers for size masks and alignment checks.
package cpu_consts;

    typedef enum logic [1:0] {
        SIZE_BYTE   = 2'd0,
        SIZE_HALF   = 2'd1,
        SIZE_WORD   = 2'd2,
        SIZE_DOUBLE = 2'd3
    } mem_size_t;

    // Memory-access FSM states
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // Writeback source selects; the MEM source is driven by rd_data_o
    localparam logic [1:0] WB_SRC_ALU = 2'd0;
    localparam logic [1:0] WB_SRC_MEM = 2'd1;
    localparam logic [1:0] WB_SRC_PC4 = 2'd2;
    localparam logic [1:0] WB_SRC_IMM = 2'd3;

    // Byte-lane mask for an access of the given size starting at lane 0
    function automatic logic [7:0] size_mask(input mem_size_t size);
        case (size)
            SIZE_BYTE: size_mask = 8'h01;
            SIZE_HALF: size_mask = 8'h03;
            SIZE_WORD: size_mask = 8'h0F;
            default:   size_mask = 8'hFF;
        endcase
    endfunction

    // Natural alignment check: the access must not straddle its own size
    function automatic logic is_misaligned(input mem_size_t size, input logic [2:0] lane);
        case (size)
            SIZE_BYTE: is_misaligned = 1'b0;
            SIZE_HALF: is_misaligned = lane[0];
            SIZE_WORD: is_misaligned = |lane[1:0];
            default:   is_misaligned = |lane;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_load_extend.sv
// Load data alignment: shift the addressed lane down, truncate to the
// access size and sign- or zero-extend to 64 bits.
module load_extend
    import cpu_consts::*;
(
    input  logic [2:0]  lane,
    input  mem_size_t   size,
    input  logic        zero_extnd,
    input  logic [63:0] raw,
    output logic [63:0] data
);

    logic [63:0] shifted;

    // Right-align the addressed bytes, then extend according to size
    always_comb begin
        shifted = raw >> {lane, 3'b000};
        data    = shifted;
        case (size)
            SIZE_BYTE: data = zero_extnd ? {56'h0, shifted[7:0]}
                                         : {{56{shifted[7]}}, shifted[7:0]};
            SIZE_HALF: data = zero_extnd ? {48'h0, shifted[15:0]}
                                         : {{48{shifted[15]}}, shifted[15:0]};
            SIZE_WORD: data = zero_extnd ? {32'h0, shifted[31:0]}
                                         : {{32{shifted[31]}}, shifted[31:0]};
            default:   data = shifted;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// Memory-stage load/store unit: captures one request, issues it to the
// data memory with lane enables, waits for grant/response with a timeout,
// and reports a one-cycle completion with fault flags.
module mem_access
    import cpu_consts::*;
#(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        mem_rd_i,
    input  logic        mem_wr_i,
    input  logic [1:0]  mem_size_i,
    input  logic        mem_zero_extnd_i,
    input  logic [63:0] addr_i,
    input  logic [63:0] wr_data_i,
    output logic        dmem_req_o,
    input  logic        dmem_gnt_i,
    output logic        dmem_wr_o,
    output logic [63:0] dmem_addr_o,
    output logic [7:0]  dmem_byte_en_o,
    output logic [63:0] dmem_wr_data_o,
    input  logic        dmem_rsp_valid_i,
    input  logic [63:0] dmem_rsp_data_i,
    output logic        rsp_valid_o,
    output logic [63:0] rd_data_o,
    output logic        misaligned_o,
    output logic        bus_err_o
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic          wr_q;
    mem_size_t     size_q;
    logic          zext_q;
    logic [63:0]   addr_q;
    logic [63:0]   wdata_q;
    logic          mis_q;
    logic          err_q;
    logic [63:0]   rd_data_q;
    logic [63:0]   ext_data;

    logic [2:0] lane;
    logic       timeout;
    logic       accept;
    logic       in_req;
    mem_size_t  size_in;

    assign size_in = mem_size_t'(mem_size_i);
    assign lane    = addr_q[2:0];
    // Last allowed cycle of REQ+WAIT; a grant or response in it still wins
    assign timeout = (cnt == CW'(TIMEOUT_CYCLES - 1));
    assign accept  = (state == ST_IDLE) && req_valid_i && (mem_rd_i || mem_wr_i);
    assign in_req  = (state == ST_REQ);

    load_extend u_load_extend (
        .lane       (lane),
        .size       (size_q),
        .zero_extnd (zext_q),
        .raw        (dmem_rsp_data_i),
        .data       (ext_data)
    );

    // FSM, request capture, timeout counter and load-data register
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            wr_q      <= 1'b0;
            size_q    <= SIZE_BYTE;
            zext_q    <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            mis_q     <= 1'b0;
            err_q     <= 1'b0;
            rd_data_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        wr_q    <= mem_wr_i;
                        size_q  <= size_in;
                        zext_q  <= mem_zero_extnd_i;
                        addr_q  <= addr_i;
                        wdata_q <= wr_data_i;
                        mis_q   <= is_misaligned(size_in, addr_i[2:0]);
                        err_q   <= 1'b0;
                        cnt     <= '0;
                        state   <= is_misaligned(size_in, addr_i[2:0]) ? ST_DONE : ST_REQ;
                    end
                end
                ST_REQ: begin
                    cnt <= cnt + 1'b1;
                    if (dmem_gnt_i) begin
                        if (wr_q) begin
                            state <= ST_DONE;
                        end else if (dmem_rsp_valid_i) begin
                            rd_data_q <= ext_data;
                            state     <= ST_DONE;
                        end else begin
                            state <= ST_WAIT;
                        end
                    end else if (timeout) begin
                        err_q <= 1'b1;
                        state <= ST_DONE;
                    end
                end
                ST_WAIT: begin
                    cnt <= cnt + 1'b1;
                    if (dmem_rsp_valid_i) begin
                        rd_data_q <= ext_data;
                        state     <= ST_DONE;
                    end else if (timeout) begin
                        err_q <= 1'b1;
                        state <= ST_DONE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Bus outputs are driven only in REQ so they stay stable until grant
    assign req_ready_o    = (state == ST_IDLE);
    assign dmem_req_o     = in_req;
    assign dmem_wr_o      = in_req && wr_q;
    assign dmem_addr_o    = in_req ? {addr_q[63:3], 3'b000} : 64'h0;
    assign dmem_byte_en_o = in_req ? (size_mask(size_q) << lane) : 8'h00;
    assign dmem_wr_data_o = (in_req && wr_q) ? (wdata_q << {lane, 3'b000}) : 64'h0;

    assign rsp_valid_o  = (state == ST_DONE);
    assign misaligned_o = (state == ST_DONE) && mis_q;
    assign bus_err_o    = (state == ST_DONE) && err_q;
    assign rd_data_o    = rd_data_q;

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: stimulus pushes the expected completion
// into a queue, a negedge monitor pops and compares on every rsp_valid_o.
module tb_mem_access;

    typedef struct {
        logic        mis;
        logic        err;
        logic [63:0] rd;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic        mem_rd_i = 1'b0;
    logic        mem_wr_i = 1'b0;
    logic [1:0]  mem_size_i = 2'd0;
    logic        mem_zero_extnd_i = 1'b0;
    logic [63:0] addr_i = '0;
    logic [63:0] wr_data_i = '0;
    logic        dmem_req_o;
    logic        dmem_gnt_i = 1'b0;
    logic        dmem_wr_o;
    logic [63:0] dmem_addr_o;
    logic [7:0]  dmem_byte_en_o;
    logic [63:0] dmem_wr_data_o;
    logic        dmem_rsp_valid_i = 1'b0;
    logic [63:0] dmem_rsp_data_i = '0;
    logic        rsp_valid_o;
    logic [63:0] rd_data_o;
    logic        misaligned_o;
    logic        bus_err_o;

    int   n_vec = 0;
    int   n_bad = 0;
    exp_t sb[$];

    mem_access #(.TIMEOUT_CYCLES(4)) dut (
        .clk              (clk),
        .reset            (reset),
        .req_valid_i      (req_valid_i),
        .req_ready_o      (req_ready_o),
        .mem_rd_i         (mem_rd_i),
        .mem_wr_i         (mem_wr_i),
        .mem_size_i       (mem_size_i),
        .mem_zero_extnd_i (mem_zero_extnd_i),
        .addr_i           (addr_i),
        .wr_data_i        (wr_data_i),
        .dmem_req_o       (dmem_req_o),
        .dmem_gnt_i       (dmem_gnt_i),
        .dmem_wr_o        (dmem_wr_o),
        .dmem_addr_o      (dmem_addr_o),
        .dmem_byte_en_o   (dmem_byte_en_o),
        .dmem_wr_data_o   (dmem_wr_data_o),
        .dmem_rsp_valid_i (dmem_rsp_valid_i),
        .dmem_rsp_data_i  (dmem_rsp_data_i),
        .rsp_valid_o      (rsp_valid_o),
        .rd_data_o        (rd_data_o),
        .misaligned_o     (misaligned_o),
        .bus_err_o        (bus_err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic mis, input logic err, input logic [63:0] rd);
        exp_t e;
        e.mis = mis;
        e.err = err;
        e.rd  = rd;
        return e;
    endfunction

    // Monitor: every completion pulse must match the oldest expectation
    always @(negedge clk) begin
        if (!reset && rsp_valid_o) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_rsp: got rsp_valid_o=1 expected no response");
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rsp_misaligned", 64'(misaligned_o), 64'(e.mis));
                chk("rsp_bus_err", 64'(bus_err_o), 64'(e.err));
                chk("rsp_rd_data", rd_data_o, e.rd);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string nm);
        for (int i = 0; i < 20 && !req_ready_o; i++) step();
        chk({nm, " ready"}, 64'(req_ready_o), 64'd1);
    endtask

    task automatic chk_bus(input string nm, input logic wr, input logic [63:0] a,
                           input logic [7:0] be, input logic [63:0] wd);
        @(negedge clk);
        chk({nm, " req"}, 64'(dmem_req_o), 64'd1);
        chk({nm, " wr"}, 64'(dmem_wr_o), 64'(wr));
        chk({nm, " addr"}, dmem_addr_o, {a[63:3], 3'b000});
        chk({nm, " be"}, 64'(dmem_byte_en_o), 64'(be));
        chk({nm, " wdata"}, dmem_wr_data_o, wd);
    endtask

    // gnt_dly < 0: never grant. rsp_dly 0: response with grant, else
    // number of WAIT cycles up to and including the response cycle.
    task automatic run_txn(input string nm, input logic rd, input logic wr,
                           input logic [1:0] sz, input logic zx,
                           input logic [63:0] a, input logic [63:0] wd,
                           input int gnt_dly, input int rsp_dly, input logic [63:0] raw,
                           input logic [7:0] exp_be, input logic [63:0] exp_wd,
                           input exp_t e);
        wait_ready(nm);
        sb.push_back(e);
        req_valid_i = 1'b1; mem_rd_i = rd; mem_wr_i = wr; mem_size_i = sz;
        mem_zero_extnd_i = zx; addr_i = a; wr_data_i = wd;
        step();
        req_valid_i = 1'b0; mem_rd_i = 1'b0; mem_wr_i = 1'b0;
        addr_i = 64'hFFFF_FFFF_FFFF_FFFF; wr_data_i = 64'hA5A5_A5A5_A5A5_A5A5;
        if (e.mis) begin
            @(negedge clk);
            chk({nm, " no_req"}, 64'(dmem_req_o), 64'd0);
            step();
        end else if (gnt_dly < 0) begin
            for (int k = 0; k < 4; k++) begin
                chk_bus(nm, wr, a, exp_be, exp_wd);
                step();
            end
            @(negedge clk);
            chk({nm, " req_dropped"}, 64'(dmem_req_o), 64'd0);
            step();
        end else begin
            for (int k = 0; k < gnt_dly; k++) begin
                chk_bus(nm, wr, a, exp_be, exp_wd);
                step();
            end
            dmem_gnt_i = 1'b1;
            if (rd && rsp_dly == 0) begin
                dmem_rsp_valid_i = 1'b1;
                dmem_rsp_data_i  = raw;
            end
            chk_bus(nm, wr, a, exp_be, exp_wd);
            step();
            dmem_gnt_i = 1'b0;
            dmem_rsp_valid_i = 1'b0;
            dmem_rsp_data_i = 64'hDEAD_DEAD_DEAD_DEAD;
            if (rd && rsp_dly > 0) begin
                for (int k = 0; k < rsp_dly - 1; k++) step();
                dmem_rsp_valid_i = 1'b1;
                dmem_rsp_data_i  = raw;
                step();
                dmem_rsp_valid_i = 1'b0;
            end
            step();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) step();
        reset = 1'b0;
        @(negedge clk);
        chk("reset ready", 64'(req_ready_o), 64'd1);
        chk("reset dmem_req", 64'(dmem_req_o), 64'd0);
        chk("reset rsp_valid", 64'(rsp_valid_o), 64'd0);
        chk("reset rd_data", rd_data_o, 64'h0);
        chk("reset misaligned", 64'(misaligned_o), 64'd0);
        chk("reset bus_err", 64'(bus_err_o), 64'd0);
        chk("reset be", 64'(dmem_byte_en_o), 64'd0);
        step();

        //      name   rd  wr  size  zx  addr       wdata   gnt rsp raw                      be     wd
        run_txn("lb",  1, 0, 2'd0, 0, 64'h1003, 64'h0, 0, 1, 64'h0000_0000_8000_0000, 8'h08, 64'h0,
                mk(0, 0, 64'hFFFF_FFFF_FFFF_FF80));
        run_txn("lbu", 1, 0, 2'd0, 1, 64'h1003, 64'h0, 1, 1, 64'h0000_0000_8000_0000, 8'h08, 64'h0,
                mk(0, 0, 64'h80));
        run_txn("sh",  0, 1, 2'd1, 0, 64'h2006, 64'hBEEF, 3, 0, 64'h0, 8'hC0, 64'hBEEF_0000_0000_0000,
                mk(0, 0, 64'h80));
        run_txn("lw_mis", 1, 0, 2'd2, 0, 64'h1002, 64'h0, 0, 0, 64'h0, 8'h00, 64'h0,
                mk(1, 0, 64'h80));
        run_txn("ld",  1, 0, 2'd3, 0, 64'h3000, 64'h0, 0, 0, 64'h0123_4567_89AB_CDEF, 8'hFF, 64'h0,
                mk(0, 0, 64'h0123_4567_89AB_CDEF));
        run_txn("lh",  1, 0, 2'd1, 0, 64'h4002, 64'h0, 0, 2, 64'h0000_0000_8001_0000, 8'h0C, 64'h0,
                mk(0, 0, 64'hFFFF_FFFF_FFFF_8001));
        run_txn("lwu", 1, 0, 2'd2, 1, 64'h5004, 64'h0, 1, 1, 64'hDEAD_BEEF_0000_0000, 8'hF0, 64'h0,
                mk(0, 0, 64'h0000_0000_DEAD_BEEF));
        run_txn("lw",  1, 0, 2'd2, 0, 64'h5004, 64'h0, 0, 0, 64'hDEAD_BEEF_0000_0000, 8'hF0, 64'h0,
                mk(0, 0, 64'hFFFF_FFFF_DEAD_BEEF));
        run_txn("sb",  0, 1, 2'd0, 0, 64'h6007, 64'h5A, 1, 0, 64'h0, 8'h80, 64'h5A00_0000_0000_0000,
                mk(0, 0, 64'hFFFF_FFFF_DEAD_BEEF));
        run_txn("sd_mis", 0, 1, 2'd3, 0, 64'h6004, 64'h1, 0, 0, 64'h0, 8'h00, 64'h0,
                mk(1, 0, 64'hFFFF_FFFF_DEAD_BEEF));
        run_txn("ld_tmo", 1, 0, 2'd3, 0, 64'h7000, 64'h0, -1, 0, 64'h0, 8'hFF, 64'h0,
                mk(0, 1, 64'hFFFF_FFFF_DEAD_BEEF));

        // Request with neither load nor store is dropped
        wait_ready("nop");
        req_valid_i = 1'b1;
        step();
        req_valid_i = 1'b0;
        @(negedge clk);
        chk("nop ready", 64'(req_ready_o), 64'd1);
        chk("nop dmem_req", 64'(dmem_req_o), 64'd0);
        step();

        // Reset while waiting for load data
        wait_ready("rst_wait");
        req_valid_i = 1'b1; mem_rd_i = 1'b1; mem_size_i = 2'd3; addr_i = 64'h8000;
        step();
        req_valid_i = 1'b0; mem_rd_i = 1'b0;
        dmem_gnt_i = 1'b1;
        step();
        dmem_gnt_i = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_wait dmem_req", 64'(dmem_req_o), 64'd0);
        chk("rst_wait ready", 64'(req_ready_o), 64'd1);
        chk("rst_wait rsp_valid", 64'(rsp_valid_o), 64'd0);
        chk("rst_wait rd_data", rd_data_o, 64'h0);

        repeat (4) step();
        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
